// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch requester
// and the load/store requester. One transaction in flight, round-robin on
// contention, fixed read latency sequenced back to the winning requester.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     ls_req,
  input  logic                     ls_we,
  input  logic [ADDRESS_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  output logic                     ls_gnt,
  output logic                     ls_rvalid,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy
);

  // state   | meaning
  // S_IDLE  | no transaction; arbitrate at the end of the cycle
  // S_ISSUE | command on the memory bus, gnt to the winner
  // S_WAIT  | read latency countdown (only when MEM_LATENCY > 1)
  // S_RESP  | read data valid to src; arbitrate for the next access
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int             CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LATENCY - 1);
  localparam logic           SRC_IF   = 1'b0;
  localparam logic           SRC_LS   = 1'b1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          src;
  logic          any_req;
  logic          pick_ls;

  // Round-robin choice: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    any_req = if_req | ls_req;
    pick_ls = ls_req & (~if_req | (last_grant == SRC_IF));
  end

  // Sequencer with registered strobes; gnt/mem_req/rvalid default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= SRC_LS;
      src        <= SRC_IF;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (any_req) begin
            state      <= S_ISSUE;
            last_grant <= pick_ls;
            src        <= pick_ls;
            mem_req    <= 1'b1;
            mem_we     <= pick_ls & ls_we;
            mem_addr   <= pick_ls ? ls_addr : if_addr;
            if (pick_ls) mem_wdata <= ls_wdata;
            if_gnt     <= ~pick_ls;
            ls_gnt     <= pick_ls;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // mem_we still holds the issued command's direction during ISSUE.
          if (mem_we) begin
            state <= S_IDLE;
          end else if (MEM_LATENCY > 1) begin
            state <= S_WAIT;
            cnt   <= CW'(1);
          end else begin
            state     <= S_RESP;
            if_rvalid <= (src == SRC_IF);
            ls_rvalid <= (src == SRC_LS);
          end
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            state     <= S_RESP;
            cnt       <= '0;
            if_rvalid <= (src == SRC_IF);
            ls_rvalid <= (src == SRC_LS);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data passes straight through in the RESP cycle, zero otherwise.
  always_comb begin
    if_rdata = if_rvalid ? mem_rdata : '0;
    ls_rdata = ls_rvalid ? mem_rdata : '0;
    busy     = (state != S_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level schedule model and a reference memory.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (latency 2)
  logic          if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid;
  logic          mem_req, mem_we, busy;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] if_rdata, ls_wdata, ls_rdata, mem_wdata, mem_rdata;

  // second DUT (latency 1)
  logic          if_req_1, if_gnt_1, if_rvalid_1, ls_req_1, ls_we_1, ls_gnt_1, ls_rvalid_1;
  logic          mem_req_1, mem_we_1, busy_1;
  logic [AW-1:0] if_addr_1, ls_addr_1, mem_addr_1;
  logic [DW-1:0] if_rdata_1, ls_wdata_1, ls_rdata_1, mem_wdata_1, mem_rdata_1;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
    .ls_req(ls_req_1), .ls_we(ls_we_1), .ls_addr(ls_addr_1), .ls_wdata(ls_wdata_1),
    .ls_gnt(ls_gnt_1), .ls_rvalid(ls_rvalid_1), .ls_rdata(ls_rdata_1),
    .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  int checks = 0;
  int errors = 0;

  // memory seen by the DUT, and the reference copy updated by the model
  logic [DW-1:0] env_mem [64];
  logic [DW-1:0] ref_mem [64];
  int            rd_due;
  logic [DW-1:0] rd_data;

  // schedule model: cycle numbers of the expected issue / response
  int            next_arb, e_iss, e_rv, busy_end;
  bit            last_ls, e_src, e_we;
  logic [AW-1:0] e_addr, cur_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  // requesters: index 0 = fetch, 1 = load/store
  bit            pend [2];
  bit            r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata [2];
  int            gen_mode;   // 0 none, 1 random, 2 both always loading

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_arb = 0;
    e_iss    = -100;
    e_rv     = -100;
    busy_end = -100;
    last_ls  = 1'b1;
    cur_addr = '0;
    rd_due   = -100;
  endtask

  // End-of-cycle decision: if the arbiter may accept in cycle t, schedule the winner.
  task automatic model_update(int t);
    bit w_ls;
    if (t >= next_arb && (if_req || ls_req)) begin
      w_ls    = ls_req && (!if_req || !last_ls);
      last_ls = w_ls;
      e_iss   = t + 1;
      e_src   = w_ls;
      e_we    = w_ls && ls_we;
      e_addr  = w_ls ? ls_addr : if_addr;
      e_wdata = ls_wdata;
      if (e_we) begin
        ref_mem[e_addr[7:2]] = e_wdata;
        next_arb = t + 2;
        busy_end = t + 1;
      end else begin
        e_rdata  = ref_mem[e_addr[7:2]];
        e_rv     = t + 1 + L;
        next_arb = t + 1 + L;
        busy_end = t + 1 + L;
      end
    end
  endtask

  task automatic apply_req();
    if_req   = pend[0];
    if_addr  = r_addr[0];
    ls_req   = pend[1];
    ls_we    = r_we[1];
    ls_addr  = r_addr[1];
    ls_wdata = r_wdata[1];
  endtask

  task automatic drive_inputs(int c);
    for (int s = 0; s < 2; s++) begin
      if (pend[s] && e_iss == c - 1 && int'(e_src) == s) pend[s] = 1'b0;
      if (pend[s] && gen_mode == 1 && e_iss != c && $urandom_range(15) == 0) pend[s] = 1'b0;
      if (!pend[s] && gen_mode != 0 && (gen_mode == 2 || $urandom_range(1) == 1)) begin
        pend[s]    = 1'b1;
        r_addr[s]  = 16'($urandom_range(63)) << 2;
        r_we[s]    = (s == 1 && gen_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        r_wdata[s] = $urandom;
      end else if (!pend[s]) begin
        r_addr[s]  = 16'($urandom);
        r_wdata[s] = $urandom;
      end
    end
    apply_req();
    mem_rdata = (rd_due == c) ? rd_data : $urandom;
  endtask

  task automatic check_outputs(int c);
    bit iss, rv;
    iss = (c == e_iss);
    rv  = (c == e_rv);
    if (iss) cur_addr = e_addr;
    chk("if_gnt", if_gnt, iss && !e_src);
    chk("ls_gnt", ls_gnt, iss && e_src);
    chk("mem_req", mem_req, iss);
    chk("mem_we", mem_we, iss && e_we);
    chk("mem_addr", mem_addr, cur_addr);
    if (iss && e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("if_rvalid", if_rvalid, rv && !e_src);
    chk("ls_rvalid", ls_rvalid, rv && e_src);
    chk("if_rdata", if_rdata, (rv && !e_src) ? e_rdata : 32'h0);
    chk("ls_rdata", ls_rdata, (rv && e_src) ? e_rdata : 32'h0);
    chk("busy", busy, c <= busy_end);
  endtask

  task automatic env_update(int c);
    if (mem_req) begin
      if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
      else begin
        rd_due  = c + L;
        rd_data = env_mem[mem_addr[7:2]];
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_inputs(cyc);
    @(negedge clk);
    check_outputs(cyc);
    env_update(cyc);
    model_update(cyc);
  endtask

  task automatic rand_inputs();
    if_req    = 1'($urandom_range(1));
    if_addr   = 16'($urandom);
    ls_req    = 1'($urandom_range(1));
    ls_we     = 1'($urandom_range(1));
    ls_addr   = 16'($urandom);
    ls_wdata  = $urandom;
    mem_rdata = $urandom;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_if_gnt"}, if_gnt, 0);
    chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ls_gnt"}, ls_gnt, 0);
    chk({tag, "_ls_rvalid"}, ls_rvalid, 0);
    chk({tag, "_ls_rdata"}, ls_rdata, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_busy_1"}, busy_1, 0);
  endtask

  // Called at a falling edge; asserts reset asynchronously mid-cycle and releases it
  // at a later falling edge with the fetch requester optionally holding a request.
  task automatic do_reset(int ncyc, bit keep_if, logic [AW-1:0] a);
    #2;
    rand_inputs();
    rst = 1'b0;
    #1 check_zero("rst_async");
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      rand_inputs();
      @(negedge clk);
      check_zero("rst_hold");
    end
    pend[0]   = keep_if;
    r_addr[0] = a;
    pend[1]   = 1'b0;
    apply_req();
    model_reset();
    rst = 1'b1;
    #1 model_update(cyc);
  endtask

  function automatic logic [DW-1:0] f1(logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  initial begin
    bit            got [8];
    int            n;
    logic [AW-1:0] a6 [4];
    logic          prev_rd;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] exp6;
    bit            odd_iss, even_rv;

    rst = 1'b0;
    gen_mode = 0;
    for (int s = 0; s < 2; s++) begin
      pend[s] = 1'b0; r_we[s] = 1'b0; r_addr[s] = '0; r_wdata[s] = '0;
    end
    apply_req();
    mem_rdata = '0;
    if_req_1 = 1'b0; if_addr_1 = '0; ls_req_1 = 1'b0; ls_we_1 = 1'b0;
    ls_addr_1 = '0; ls_wdata_1 = '0; mem_rdata_1 = '0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    model_reset();

    // reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;
    #1 model_update(cyc);
    step(); step();

    // T2: single fetch
    env_mem[1] = 32'h00500093;
    ref_mem[1] = 32'h00500093;
    pend[0] = 1'b1; r_addr[0] = 16'h0004; r_we[0] = 1'b0;
    step();
    step();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_we", mem_we, 0);
    chk("t2_mem_addr", mem_addr, 16'h0004);
    chk("t2_if_gnt", if_gnt, 1);
    step();
    step();
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, 32'h00500093);
    step();

    // T3: single store
    pend[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 16'h0100; r_wdata[1] = 32'hDEADBEEF;
    step();
    step();
    chk("t3_mem_req", mem_req, 1);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_addr", mem_addr, 16'h0100);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t3_ls_gnt", ls_gnt, 1);
    step();
    chk("t3_busy", busy, 0);
    for (int i = 0; i < 4; i++) step();

    // T4: contention, last winner was LS so fetch goes first
    gen_mode = 2;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      step();
      if (if_gnt || ls_gnt) begin
        got[n] = ls_gnt;
        n++;
      end
    end
    chk("t4_grant_count", n, 8);
    for (int i = 0; i < n; i++) chk("t4_grant_src", got[i], i % 2);
    gen_mode = 0;
    for (int i = 0; i < 12; i++) step();

    // randomized traffic, reset in the middle of it, more traffic
    gen_mode = 1;
    for (int i = 0; i < 400; i++) step();
    do_reset(2, 1'b0, '0);
    for (int i = 0; i < 200; i++) step();
    gen_mode = 0;
    for (int i = 0; i < 12; i++) step();

    // T5: reset while a fetch read is in WAIT
    pend[0] = 1'b1; r_addr[0] = 16'h0020; r_we[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cyc == e_iss + 1) begin
        n = 1;
        break;
      end
    end
    chk("t5_reached_wait", n, 1);
    chk("t5_busy_in_wait", busy, 1);
    do_reset(2, 1'b1, 16'h0040);
    step();
    chk("t5_regnt", if_gnt, 1);
    chk("t5_readdr", mem_addr, 16'h0040);
    for (int i = 0; i < 6; i++) step();

    // T6: back-to-back loads on the latency-1 instance
    for (int i = 0; i < 4; i++) a6[i] = 16'($urandom_range(16383)) << 2;
    prev_rd = 1'b0;
    prev_a  = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      ls_req_1    = (k < 8);
      ls_addr_1   = a6[(k < 8) ? k / 2 : 3];
      mem_rdata_1 = prev_rd ? f1(prev_a) : $urandom;
      @(negedge clk);
      odd_iss = (k % 2 == 1) && (k <= 7);
      even_rv = (k % 2 == 0) && (k >= 2) && (k <= 8);
      chk("t6_mem_req", mem_req_1, odd_iss);
      chk("t6_mem_we", mem_we_1, 0);
      chk("t6_ls_gnt", ls_gnt_1, odd_iss);
      if (odd_iss) chk("t6_mem_addr", mem_addr_1, a6[k / 2]);
      chk("t6_ls_rvalid", ls_rvalid_1, even_rv);
      exp6 = '0;
      if (even_rv) exp6 = f1(a6[k / 2 - 1]);
      chk("t6_ls_rdata", ls_rdata_1, exp6);
      chk("t6_busy", busy_1, (k >= 1) && (k <= 8));
      prev_rd = mem_req_1 && !mem_we_1;
      prev_a  = mem_addr_1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
